// File: rtl/riscv_fetch_ctrl.sv
// Multi-cycle fetch/decode/exec/commit sequencer with fetch watchdog and halt path.
// Optional retired-instruction counter enabled by defining RISCV_FETCH_CTRL_RETIRE_CNT_EN.
package riscv_constants;
  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_PLUS4  = 2'd1,
    PC_TARGET = 2'd2
  } pc_sel_e;
endpackage

module riscv_fetch_ctrl
  import riscv_constants::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             x_reset,
  input  logic             start,
  input  logic             halt_req,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             instr_valid,
  input  logic             ex_done,
  input  logic             branch_taken,
  output pc_sel_e          pc_sel,
  output logic             busy,
  output logic             halted,
  output logic             fetch_err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_COMMIT = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e     state_reg, state_next;
  logic [7:0] tmo_reg, tmo_next;
  logic       branch_reg, branch_next;
  logic       err_reg, err_next;

  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      state_reg  <= S_IDLE;
      tmo_reg    <= '0;
      branch_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tmo_reg    <= tmo_next;
      branch_reg <= branch_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    tmo_next    = '0;
    branch_next = branch_reg;
    err_next    = err_reg;
    case (state_reg)
      S_IDLE: begin
        // halt takes priority over start at an idle boundary
        if (halt_req)   state_next = S_HALT;
        else if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          state_next = S_DECODE;
        end else if (tmo_reg == TMO_LAST) begin
          state_next = S_HALT;
          err_next   = 1'b1;
        end else begin
          tmo_next = tmo_reg + 8'd1;
        end
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (ex_done) begin
          branch_next = branch_taken;
          state_next  = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (halt_req)   state_next = S_HALT;
        else if (start) state_next = S_FETCH;
        else            state_next = S_IDLE;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // All outputs decode from registered state only.
  assign imem_req    = (state_reg == S_FETCH);
  assign instr_valid = (state_reg == S_DECODE);
  assign busy        = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                       (state_reg == S_EXEC)  || (state_reg == S_COMMIT);
  assign halted      = (state_reg == S_HALT);
  assign fetch_err   = err_reg;
  assign pc_sel      = (state_reg != S_COMMIT) ? PC_HOLD :
                       (branch_reg ? PC_TARGET : PC_PLUS4);

`ifdef RISCV_FETCH_CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] instret_reg;

  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      instret_reg <= '0;
    end else if (state_reg == S_COMMIT) begin
      instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  assign instret = instret_reg;
`else
  assign instret = '0;
`endif

endmodule
